e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the decode stage.
- Consumes the decoded md/mt/mf instruction class plus the forwarded rs/rt values, and owns the HI/LO registers.
- Runs multi-cycle multiply and divide operations.
- Produces a busy indication that the hazard unit uses to stall md-class instructions in D, and the MFHI/MFLO read result for the E-stage result mux.

Parameters:
- MUL_CYCLES, 5, number of busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- E_MDvalid  input  1  the E-stage instruction is a real (non-bubble) md/mt/mf op.
- E_MDop  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 are treated as NONE.
- E_A  input  32  forwarded rs value.
- E_B  input  32  forwarded rt value.
- E_MDstart  output  1  combinational; a mult/div is being accepted this cycle.
- E_MDbusy  output  1  registered; a mult/div is in progress.
- E_MDout  output  32  combinational MFHI/MFLO result.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.

Behaviour:
- States: IDLE, MUL_RUN, DIV_RUN.
  - A counter cnt is sized to hold max(MUL_CYCLES, DIV_CYCLES).
  - The pending result registers are res_hi and res_lo.
- Reset (reset==0, asynchronous):
  - state = IDLE, cnt = 0, HI = 0, LO = 0, res_hi = res_lo = 0.
  - Consequently E_MDbusy = 0 and E_MDout = 0.
  - Reset mid-operation aborts the operation; no commit occurs after reset releases.
- E_MDstart = E_MDvalid & (op in 1..4) & (state==IDLE).
- At an accepting edge:
  - The full result is computed from E_A/E_B and stored in res_hi/res_lo.
  - cnt is loaded with MUL_CYCLES or DIV_CYCLES.
  - state goes to MUL_RUN or DIV_RUN.
- While in a RUN state:
  - Each edge decrements cnt.
  - At the edge where cnt==1: HI <= res_hi, LO <= res_lo, state <= IDLE.
- Timing: with start sampled at edge N, E_MDbusy is high for exactly LAT cycles after N. The new HI/LO values are first visible in the cycle where E_MDbusy has returned to 0.
- E_MDbusy = (state != IDLE). The hazard unit stalls D when a D-stage md instruction coincides with E_MDstart | E_MDbusy.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: unsigned 32x32 -> 64, same HI/LO split as MULT.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, which carries the sign of the dividend.
  - DIV special case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (E_B==0, DIV or DIVU): the operation runs its full DIV_CYCLES busy time, then HI and LO keep their previous values (no commit).
- MTHI/MTLO:
  - When E_MDvalid and state==IDLE, HI (or LO) <= E_A at the next edge.
  - If issued while busy they are ignored; the pipeline guarantees this never happens.
- MFHI/MFLO:
  - E_MDout = HI (op 7) or LO (op 8), combinational from the committed registers, independent of state.
  - E_MDout = 0 for all other ops or when E_MDvalid==0.
- Mult/div ops presented while busy: ignored; the running operation is unaffected.
- E_MDvalid==0: no state change except normal RUN progression.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5:
  - E_MDstart=1 for one cycle, then E_MDbusy=1 for exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFLO then yields E_MDout=0xFFFFFFF1.
- DIVU A=100 B=7:
  - busy for 10 cycles, then LO=14, HI=2.
- DIV A=0xFFFFFFF9 (-7), B=2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF:
  - LO=0x80000000, HI=0.
- Divide by zero:
  - Setup: MTHI 0x12345678, then MTLO 0x9ABCDEF0.
  - Stimulus: DIV A=5, B=0.
  - busy for 10 cycles, then HI/LO unchanged; MFHI yields 0x12345678.
- Reset and busy handling:
  - Start MULTU 0xFFFFFFFF*0xFFFFFFFF; during cycle 2 of busy, present DIVU 9/3 with E_MDvalid=1.
    - The DIVU is ignored.
    - After 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
  - Second run: start DIV 9/3, then pulse reset low in busy cycle 4.
    - busy=0 and HI=LO=0 immediately.
    - After release there is no later commit; HI/LO stay 0.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: EX-stage multiply/divide unit. Owns HI/LO, runs multi-cycle
// MULT/MULTU/DIV/DIVU, and serves MTHI/MTLO writes and MFHI/MFLO reads.
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDvalid,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDstart,
  output logic        E_MDbusy,
  output logic [31:0] E_MDout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic               div_zero_q, div_zero_d;  // divide by zero: run, but skip commit
  logic               busy_q, busy_d;

  logic               is_md_op;
  logic signed [63:0] a_s64, b_s64, mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        divisor, sdiv_q, sdiv_r, udiv_q, udiv_r;

  assign is_md_op  = (E_MDop >= OP_MULT) && (E_MDop <= OP_DIVU);
  assign E_MDstart = E_MDvalid && is_md_op && (state_q == IDLE);
  assign E_MDbusy  = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

  // Full-width products and quotients computed from the operands on the accepting cycle.
  always_comb begin
    a_s64   = {{32{E_A[31]}}, E_A};
    b_s64   = {{32{E_B[31]}}, E_B};
    mul_s   = a_s64 * b_s64;
    mul_u   = {32'd0, E_A} * {32'd0, E_B};
    // Substitute a divisor of 1 on divide-by-zero so the quotient is never X;
    // that result is discarded at commit time anyway.
    divisor = (E_B == 32'd0) ? 32'd1 : E_B;
    udiv_q  = E_A / divisor;
    udiv_r  = E_A % divisor;
    if (E_A == 32'h8000_0000 && E_B == 32'hFFFF_FFFF) begin
      sdiv_q = 32'h8000_0000;
      sdiv_r = 32'd0;
    end else begin
      sdiv_q = $signed(E_A) / $signed(divisor);
      sdiv_r = $signed(E_A) % $signed(divisor);
    end
  end

  // Next-state logic: accept an op when idle, count down while running, commit on the last cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (E_MDstart) begin
          div_zero_d = 1'b0;
          cnt_d      = CNT_W'(MUL_CYCLES);
          state_d    = MUL_RUN;
          case (E_MDop)
            OP_MULT:  {res_hi_d, res_lo_d} = mul_s;
            OP_MULTU: {res_hi_d, res_lo_d} = mul_u;
            OP_DIV: begin
              {res_hi_d, res_lo_d} = {sdiv_r, sdiv_q};
              div_zero_d           = (E_B == 32'd0);
              cnt_d                = CNT_W'(DIV_CYCLES);
              state_d              = DIV_RUN;
            end
            default: begin  // OP_DIVU
              {res_hi_d, res_lo_d} = {udiv_r, udiv_q};
              div_zero_d           = (E_B == 32'd0);
              cnt_d                = CNT_W'(DIV_CYCLES);
              state_d              = DIV_RUN;
            end
          endcase
        end else if (E_MDvalid && E_MDop == OP_MTHI) begin
          hi_d = E_A;
        end else if (E_MDvalid && E_MDop == OP_MTLO) begin
          lo_d = E_A;
        end
      end
      MUL_RUN, DIV_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!div_zero_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // MFHI/MFLO read port straight from the committed registers.
  always_comb begin
    E_MDout = 32'd0;
    if (E_MDvalid && E_MDop == OP_MFHI) E_MDout = hi_q;
    else if (E_MDvalid && E_MDop == OP_MFLO) E_MDout = lo_q;
  end

  // State and data registers; reset aborts any running operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu. Stimulus pushes expected start flags,
// MF read values and HI/LO commits; a negedge monitor pops and compares.
module tb_e_mdu;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_MDvalid;
  logic [3:0]  E_MDop;
  logic [31:0] E_A, E_B;
  logic        E_MDstart, E_MDbusy;
  logic [31:0] E_MDout, HI, LO;

  e_mdu #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .E_MDvalid(E_MDvalid), .E_MDop(E_MDop),
    .E_A(E_A), .E_B(E_B), .E_MDstart(E_MDstart), .E_MDbusy(E_MDbusy),
    .E_MDout(E_MDout), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } commit_t;

  commit_t     commit_q[$];
  logic        start_q[$];
  logic [31:0] mf_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: committed HI/LO, pending result, remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  bit          m_pend_commit;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mult/div from the instruction definitions.
  function automatic void ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output bit commit);
    longint          sa, sb, p;
    longint unsigned ua, ub, up, mag_a, mag_b, q, r;
    commit = 1'b1;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      4'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        {hi, lo} = p;
      end
      4'd2: begin
        ua = a;
        ub = b;
        up = ua * ub;
        {hi, lo} = up;
      end
      4'd3: begin
        if (b == 32'd0) commit = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          sa    = longint'($signed(a));
          sb    = longint'($signed(b));
          mag_a = (sa < 0) ? -sa : sa;
          mag_b = (sb < 0) ? -sb : sb;
          q     = mag_a / mag_b;
          r     = mag_a - q * mag_b;
          lo    = ((sa < 0) != (sb < 0)) ? 32'(-q) : 32'(q);
          hi    = (sa < 0) ? 32'(-r) : 32'(r);
        end
      end
      4'd4: begin
        if (b == 32'd0) commit = 1'b0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: commit = 1'b0;
    endcase
  endfunction

  // Drive one cycle of input, record expectations, advance the model by one edge.
  task automatic step(input bit valid, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          is_md, accept, ok;
    logic [31:0] rh, rl;
    commit_t     c;
    E_MDvalid = valid;
    E_MDop    = op;
    E_A       = a;
    E_B       = b;
    is_md  = (op >= 4'd1) && (op <= 4'd4);
    accept = valid && is_md && (m_cnt == 0);
    if (valid) start_q.push_back(accept);
    if (valid && op == 4'd7) mf_q.push_back(m_hi);
    if (valid && op == 4'd8) mf_q.push_back(m_lo);
    if (accept) begin
      ref_result(op, a, b, rh, rl, ok);
      m_pend_hi     = rh;
      m_pend_lo     = rl;
      m_pend_commit = ok;
      m_cnt         = (op <= 4'd2) ? MUL_LAT : DIV_LAT;
      c.hi  = ok ? rh : m_hi;
      c.lo  = ok ? rl : m_lo;
      c.lat = m_cnt;
      commit_q.push_back(c);
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_pend_commit) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (valid && op == 4'd5) m_hi = a;
    else if (valid && op == 4'd6) m_lo = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_pend_hi = 32'd0; m_pend_lo = 32'd0;
    m_pend_commit = 1'b0; m_cnt = 0;
    commit_q.delete(); start_q.delete(); mf_q.delete();
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin : monitor
    bit          busy_prev;
    int          busy_len;
    commit_t     c;
    busy_prev = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_prev = 1'b0;
        busy_len  = 0;
      end else begin
        if (E_MDvalid) begin
          if (start_q.size() == 0) begin
            n_fail++;
            $display("FAIL start_q_empty: valid op seen with no expectation at %0t", $time);
          end else check("start", 64'(E_MDstart), 64'(start_q.pop_front()));
          if (E_MDop == 4'd7 || E_MDop == 4'd8) begin
            if (mf_q.size() == 0) begin
              n_fail++;
              $display("FAIL mf_q_empty: MF read with no expectation at %0t", $time);
            end else check("mf_out", 64'(E_MDout), 64'(mf_q.pop_front()));
          end else check("out_zero", 64'(E_MDout), 64'd0);
        end
        if (E_MDbusy) begin
          busy_len++;
          if (busy_len == 64) begin
            n_fail++;
            $display("FAIL busy_stuck: busy for %0d cycles", busy_len);
          end
        end
        if (busy_prev && !E_MDbusy) begin
          if (commit_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_commit: busy fell with nothing pending at %0t", $time);
          end else begin
            c = commit_q.pop_front();
            check("busy_len", 64'(busy_len), 64'(c.lat));
            check("commit_hi", 64'(HI), 64'(c.hi));
            check("commit_lo", 64'(LO), 64'(c.lo));
          end
          busy_len = 0;
        end
        busy_prev = E_MDbusy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0]  op;
    logic [31:0] a, b;
    int          wait_cnt;
    reset = 1'b0; E_MDvalid = 1'b0; E_MDop = 4'd0; E_A = 32'd0; E_B = 32'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 64'(E_MDbusy), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_out", 64'(E_MDout), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MULT -3 * 5
    step(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5);
    idle(6);
    step(1'b1, 4'd8, 32'd0, 32'd0);
    check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
    check("mult_lo", 64'(LO), 64'hFFFF_FFF1);

    // DIVU 100 / 7
    step(1'b1, 4'd4, 32'd100, 32'd7);
    idle(11);
    check("divu_lo", 64'(LO), 64'd14);
    check("divu_hi", 64'(HI), 64'd2);

    // DIV -7 / 2
    step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(11);
    check("div_lo", 64'(LO), 64'hFFFF_FFFD);
    check("div_hi", 64'(HI), 64'hFFFF_FFFF);

    // DIV overflow case
    step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(11);
    check("divovf_lo", 64'(LO), 64'h8000_0000);
    check("divovf_hi", 64'(HI), 64'd0);

    // Divide by zero keeps HI/LO
    step(1'b1, 4'd5, 32'h1234_5678, 32'd0);
    step(1'b1, 4'd6, 32'h9ABC_DEF0, 32'd0);
    step(1'b1, 4'd3, 32'd5, 32'd0);
    idle(11);
    step(1'b1, 4'd7, 32'd0, 32'd0);
    check("div0_hi", 64'(HI), 64'h1234_5678);
    check("div0_lo", 64'(LO), 64'h9ABC_DEF0);

    // MULTU with a DIVU presented in busy cycle 2
    step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);
    step(1'b1, 4'd4, 32'd9, 32'd3);
    idle(5);
    check("multu_hi", 64'(HI), 64'hFFFF_FFFE);
    check("multu_lo", 64'(LO), 64'h0000_0001);
    check("multu_idle", 64'(E_MDbusy), 64'd0);

    // DIV 9/3 aborted by reset in busy cycle 4
    step(1'b1, 4'd3, 32'd9, 32'd3);
    idle(3);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(E_MDbusy), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    idle(15);
    step(1'b1, 4'd7, 32'd0, 32'd0);
    step(1'b1, 4'd8, 32'd0, 32'd0);
    check("abort_hi_after", 64'(HI), 64'd0);
    check("abort_lo_after", 64'(LO), 64'd0);

    // Randomized mix of all ops, gaps and corner operands
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op > 4'd9) op = 4'($urandom_range(1, 4));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(9, 15));
      step($urandom_range(0, 4) != 0, op, a, b);
    end

    idle(12);
    wait_cnt = 0;
    while (commit_q.size() != 0 && wait_cnt < 50) begin
      idle(1);
      wait_cnt++;
    end
    check("commit_q_drained", 64'(commit_q.size()), 64'd0);
    check("start_q_drained", 64'(start_q.size()), 64'd0);
    check("mf_q_drained", 64'(mf_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
